// File: rtl/mod_count_bank.sv
// mod_count_bank: bank of independent loadable down-counters with one-shot or
// auto-reload terminal behaviour, per-channel pulse/done flags and bank reductions.
module mod_count_bank #(
    parameter int                WIDTH     = 16,
    parameter int                CHANNELS  = 4,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS-1:0]          load_i,
    input  logic [CHANNELS*WIDTH-1:0]    load_val_i,
    input  logic [CHANNELS-1:0]          dec_i,
    input  logic [CHANNELS-1:0]          auto_reload_i,
    input  logic [CHANNELS-1:0]          clr_done_i,
    output logic [CHANNELS*WIDTH-1:0]    count_o,
    output logic [CHANNELS-1:0]          is_zero_o,
    output logic [CHANNELS-1:0]          zero_pulse_o,
    output logic [CHANNELS-1:0]          done_o,
    output logic                         all_zero_o,
    output logic                         any_pulse_o
);
    logic [CHANNELS-1:0][WIDTH-1:0] count_q, count_d, reload_q, reload_d;
    logic [CHANNELS-1:0]            pulse_q, pulse_d, done_q, done_d, term;

    always_comb begin
        count_d   = count_q;
        reload_d  = reload_q;
        pulse_d   = '0;
        done_d    = done_q;
        term      = '0;
        is_zero_o = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            // load outranks dec; a dec at zero is a no-op in both modes
            term[i]      = !load_i[i] && dec_i[i] && count_q[i] == WIDTH'(1);
            count_d[i]   = load_i[i] ? load_val_i[i*WIDTH +: WIDTH] :
                           term[i] ? (auto_reload_i[i] ? reload_q[i] : '0) :
                           (dec_i[i] && count_q[i] > WIDTH'(1)) ? count_q[i] - WIDTH'(1) :
                           count_q[i];
            reload_d[i]  = load_i[i] ? load_val_i[i*WIDTH +: WIDTH] : reload_q[i];
            pulse_d[i]   = term[i];
            done_d[i]    = load_i[i] ? 1'b0 : term[i] ? 1'b1 : clr_done_i[i] ? 1'b0 : done_q[i];
            is_zero_o[i] = count_q[i] == '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= {CHANNELS{RESET_VAL}};
            reload_q <= {CHANNELS{RESET_VAL}};
            pulse_q  <= '0;
            done_q   <= '0;
        end else begin
            count_q  <= count_d;
            reload_q <= reload_d;
            pulse_q  <= pulse_d;
            done_q   <= done_d;
        end
    end

    assign count_o      = count_q;
    assign zero_pulse_o = pulse_q;
    assign done_o       = done_q;
    assign all_zero_o   = &is_zero_o;
    assign any_pulse_o  = |pulse_q;
endmodule

// File: tb/tb_mod_count_bank.sv
// tb_mod_count_bank: directed and randomized checks of mod_count_bank against a
// per-channel behavioural model; a second instance covers a non-zero reset value.
module tb_mod_count_bank;
    logic        clk = 0;
    logic        rst = 1;
    logic [3:0]  load = 0, dec = 0, ar = 0, clr = 0;
    logic [63:0] load_val = 0;
    logic [63:0] count;
    logic [3:0]  is_zero, zp, done;
    logic        all_zero, any_pulse;

    logic        b_rst = 1;
    logic [3:0]  b_load = 0, b_dec = 0, b_ar = 0;
    logic [63:0] b_load_val = 0;
    logic [63:0] b_count;
    logic [3:0]  b_is_zero, b_zp, b_done;
    logic        b_all_zero, b_any_pulse;

    int n_tests = 0, n_fail = 0;
    int m_cnt[4], m_rld[4];
    bit m_zp[4], m_done[4];

    always #5 clk = ~clk;

    mod_count_bank #(.WIDTH(16), .CHANNELS(4), .RESET_VAL(16'd0)) dut (
        .clk(clk), .rst(rst), .load_i(load), .load_val_i(load_val), .dec_i(dec),
        .auto_reload_i(ar), .clr_done_i(clr), .count_o(count), .is_zero_o(is_zero),
        .zero_pulse_o(zp), .done_o(done), .all_zero_o(all_zero), .any_pulse_o(any_pulse));

    mod_count_bank #(.WIDTH(16), .CHANNELS(4), .RESET_VAL(16'd7)) dut_b (
        .clk(clk), .rst(b_rst), .load_i(b_load), .load_val_i(b_load_val), .dec_i(b_dec),
        .auto_reload_i(b_ar), .clr_done_i(4'b0), .count_o(b_count), .is_zero_o(b_is_zero),
        .zero_pulse_o(b_zp), .done_o(b_done), .all_zero_o(b_all_zero), .any_pulse_o(b_any_pulse));

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        logic [3:0] ez, ep;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("count%0d", c), 64'(count[c*16 +: 16]), 64'(m_cnt[c]));
            check($sformatf("pulse%0d", c), 64'(zp[c]), 64'(m_zp[c]));
            check($sformatf("done%0d", c), 64'(done[c]), 64'(m_done[c]));
            ez[c] = m_cnt[c] == 0;
            ep[c] = m_zp[c];
        end
        check("is_zero", 64'(is_zero), 64'(ez));
        check("all_zero", 64'(all_zero), 64'(ez == 4'hf));
        check("any_pulse", 64'(any_pulse), 64'(ep != 4'h0));
    endtask

    // model advances from the inputs present before the edge, then outputs are compared
    task automatic tick();
        int lv;
        bit hit;
        for (int c = 0; c < 4; c++) begin
            lv  = int'(load_val[c*16 +: 16]);
            hit = 0;
            if (load[c]) begin
                m_cnt[c]  = lv;
                m_rld[c]  = lv;
                m_done[c] = 0;
            end else if (dec[c] && m_cnt[c] > 0) begin
                m_cnt[c] = m_cnt[c] - 1;
                if (m_cnt[c] == 0) begin
                    hit = 1;
                    if (ar[c]) m_cnt[c] = m_rld[c];
                    m_done[c] = 1;
                end
            end
            if (clr[c] && !hit) m_done[c] = 0;
            m_zp[c] = hit;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic b_tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_ar[9] = '{2, 1, 3, 2, 1, 3, 2, 1, 3};
        int pulses;
        for (int c = 0; c < 4; c++) begin
            m_cnt[c] = 0; m_rld[c] = 0; m_zp[c] = 0; m_done[c] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 0;
        b_rst = 0;
        #1;
        check("rst_count", count, 64'h0);
        check("rst_is_zero", 64'(is_zero), 64'hf);
        check("rst_all_zero", 64'(all_zero), 64'h1);
        check("rst_done", 64'(done), 64'h0);
        check("rst_pulse", 64'(zp), 64'h0);
        check("rst_b_count2", 64'(b_count[32 +: 16]), 64'd7);

        dec = 4'hf;
        repeat (3) begin
            tick();
            check("zero_dec_count", count, 64'h0);
            check("zero_dec_pulse", 64'(zp), 64'h0);
        end
        dec = 0;

        // one-shot countdown on channel 0
        load[0] = 1; load_val[15:0] = 16'd5;
        tick();
        check("os_load", 64'(count[15:0]), 64'd5);
        load[0] = 0; dec[0] = 1;
        for (int k = 0; k < 7; k++) begin
            tick();
            check("os_count", 64'(count[15:0]), 64'(k < 4 ? 4 - k : 0));
            check("os_pulse", 64'(zp[0]), 64'(k == 4));
        end
        dec[0] = 0;
        tick();
        check("os_done_hold", 64'(done[0]), 64'd1);
        clr[0] = 1;
        tick();
        check("os_done_clr", 64'(done[0]), 64'd0);
        clr[0] = 0;

        // auto-reload on channel 1
        load[1] = 1; load_val[31:16] = 16'd3; ar[1] = 1;
        tick();
        load[1] = 0; dec[1] = 1;
        pulses = 0;
        for (int k = 0; k < 9; k++) begin
            tick();
            check("ar_count", 64'(count[31:16]), 64'(exp_ar[k]));
            check("ar_pulse", 64'(zp[1]), 64'(exp_ar[k] == 3));
            check("ar_any", 64'(any_pulse), 64'(zp[1]));
            pulses += int'(zp[1]);
        end
        check("ar_pulses", 64'(pulses), 64'd3);
        dec[1] = 0; ar[1] = 0;

        // load beats dec; clr_done loses to a terminal event; load clears done
        load[3] = 1; dec[3] = 1; load_val[63:48] = 16'd10;
        tick();
        check("ld_dec", 64'(count[63:48]), 64'd10);
        load_val[63:48] = 16'd2;
        tick();
        load[3] = 0;
        tick();
        check("pre_term", 64'(count[63:48]), 64'd1);
        clr[3] = 1;
        tick();
        check("clr_vs_term", 64'(done[3]), 64'd1);
        clr[3] = 0; dec[3] = 0;
        load[3] = 1; load_val[63:48] = 16'd6;
        tick();
        check("ld_clr_done", 64'(done[3]), 64'd0);
        load[3] = 0;

        // randomized concurrent traffic on all channels
        repeat (400) begin
            for (int c = 0; c < 4; c++) begin
                load[c] = $urandom_range(0, 9) == 0;
                load_val[c*16 +: 16] = 16'($urandom_range(0, 6));
                dec[c] = $urandom_range(0, 3) != 0;
                ar[c] = $urandom_range(0, 1) == 1;
                clr[c] = $urandom_range(0, 7) == 0;
            end
            tick();
        end
        load = 0; dec = 0; clr = 0; ar = 0;

        // asynchronous reset mid-count on the RESET_VAL=7 instance
        b_load[2] = 1; b_load_val[47:32] = 16'd4; b_ar[2] = 1;
        b_tick();
        b_load[2] = 0; b_dec[2] = 1;
        repeat (4) b_tick();
        check("b_pre_count", 64'(b_count[47:32]), 64'd4);
        check("b_pre_pulse", 64'(b_zp[2]), 64'd1);
        b_dec[2] = 0; b_ar[2] = 0;
        #2 b_rst = 1;
        #1;
        check("b_rst_count", 64'(b_count[47:32]), 64'd7);
        check("b_rst_pulse", 64'(b_zp[2]), 64'd0);
        check("b_rst_all_zero", 64'(b_all_zero), 64'd0);
        #1 b_rst = 0;
        b_dec[2] = 1;
        for (int k = 0; k < 7; k++) begin
            b_tick();
            check("b_count", 64'(b_count[47:32]), 64'(6 - k));
            check("b_pulse", 64'(b_zp[2]), 64'(k == 6));
        end
        b_dec[2] = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
